// File: rtl/vfxp_round_wb_if.sv
// rtl/vfxp_round_wb_if.sv - bundled input/output signals of the rounding writeback stage
//
// Purpose: groups the producer-side result fields, the FIFO head fields and
//          the status flags of vfxp_round_wb into one bundle.
// Modports:
//   master : the ALU-side producer and writeback consumer (drives in_*, out_ready)
//   slave  : the vfxp_round_wb block (drives out_*, full, overflow)
// Signals:
//   in_vec/in_valid/in_addr/in_be/in_mask/in_fxp/in_vd/in_vd1/in_sew/in_vxrm
//   out_vec/out_addr/out_be/out_mask/out_valid/out_ready, full, overflow

interface vfxp_round_wb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_vec;
    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [BE_WIDTH-1:0]   in_be;
    logic                  in_mask;
    logic                  in_fxp;
    logic [BE_WIDTH-1:0]   in_vd;
    logic [BE_WIDTH-1:0]   in_vd1;
    logic [1:0]            in_sew;
    logic [1:0]            in_vxrm;

    logic [DATA_WIDTH-1:0] out_vec;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [BE_WIDTH-1:0]   out_be;
    logic                  out_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic                  full;
    logic                  overflow;

    modport master (
        output in_vec, in_valid, in_addr, in_be, in_mask, in_fxp,
               in_vd, in_vd1, in_sew, in_vxrm, out_ready,
        input  out_vec, out_addr, out_be, out_mask, out_valid, full, overflow
    );

    modport slave (
        input  in_vec, in_valid, in_addr, in_be, in_mask, in_fxp,
               in_vd, in_vd1, in_sew, in_vxrm, out_ready,
        output out_vec, out_addr, out_be, out_mask, out_valid, full, overflow
    );
endinterface

// File: rtl/vfxp_round_wb.sv
// rtl/vfxp_round_wb.sv - vector fixed-point rounding increment plus writeback FIFO
//
// Purpose: applies the per-element rounding increment selected by vxrm to an
//          ALU result word, registers it in stage s1, then queues it in a
//          FIFO_DEPTH-entry writeback buffer drained by a valid/ready consumer.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : vfxp_round_wb_if.slave
//          in_*        result word, address, byte enables and rounding info
//          out_*       FIFO head fields (zero while the FIFO is empty)
//          out_ready   consumer accepts the head this cycle
//          full        FIFO holds FIFO_DEPTH entries
//          overflow    sticky, an s1 entry was dropped against a full FIFO

module vfxp_round_wb #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    vfxp_round_wb_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Rounding increment for one element from its LSB (vd) and the first
    // shifted-out bit (vd1).
    function automatic logic round_inc(input logic [1:0] vxrm,
                                       input logic       vd,
                                       input logic       vd1);
        case (vxrm)
            2'd0:    return vd1;         // round-to-nearest-up
            2'd1:    return vd1 & vd;    // round-to-nearest-even
            2'd2:    return 1'b0;        // round-down (truncate)
            default: return vd1 & ~vd;   // round-to-odd (jam)
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Rounding datapath
    // ------------------------------------------------------------------
    logic [BE_WIDTH-1:0]   inc_b;
    logic [DATA_WIDTH-1:0] sum8;
    logic [DATA_WIDTH-1:0] sum16;
    logic [DATA_WIDTH-1:0] sum32;
    logic [DATA_WIDTH-1:0] sum64;
    logic [DATA_WIDTH-1:0] rounded;

    // The increment is evaluated at every byte; each element width then
    // picks the flag at its lowest byte index.
    always_comb begin
        inc_b = '0;
        for (int b = 0; b < BE_WIDTH; b++) begin
            inc_b[b] = round_inc(bus.in_vxrm, bus.in_vd[b], bus.in_vd1[b]);
        end
    end

    // One adder per element at each width; the part-select bounds keep the
    // carry out of every element from reaching its neighbour.
    always_comb begin
        sum8  = bus.in_vec;
        sum16 = bus.in_vec;
        sum32 = bus.in_vec;
        sum64 = bus.in_vec;
        for (int e = 0; e < DATA_WIDTH / 8; e++) begin
            sum8[e*8 +: 8] = bus.in_vec[e*8 +: 8] + 8'(inc_b[e]);
        end
        for (int e = 0; e < DATA_WIDTH / 16; e++) begin
            sum16[e*16 +: 16] = bus.in_vec[e*16 +: 16] + 16'(inc_b[e*2]);
        end
        for (int e = 0; e < DATA_WIDTH / 32; e++) begin
            sum32[e*32 +: 32] = bus.in_vec[e*32 +: 32] + 32'(inc_b[e*4]);
        end
        for (int e = 0; e < DATA_WIDTH / 64; e++) begin
            sum64[e*64 +: 64] = bus.in_vec[e*64 +: 64] + 64'(inc_b[e*8]);
        end
    end

    always_comb begin
        case (bus.in_sew)
            2'd0:    rounded = sum8;
            2'd1:    rounded = sum16;
            2'd2:    rounded = sum32;
            default: rounded = sum64;
        endcase
        // Mask results and non-fixed-point words are written back untouched.
        if (!bus.in_fxp || bus.in_mask) begin
            rounded = bus.in_vec;
        end
    end

    // ------------------------------------------------------------------
    // Stage s1
    // ------------------------------------------------------------------
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_vec_q,   s1_vec_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
    logic [BE_WIDTH-1:0]   s1_be_q,    s1_be_d;
    logic                  s1_mask_q,  s1_mask_d;

    // Payload only loads on a valid input so idle cycles do not toggle it.
    always_comb begin
        s1_valid_d = bus.in_valid;
        s1_vec_d   = s1_vec_q;
        s1_addr_d  = s1_addr_q;
        s1_be_d    = s1_be_q;
        s1_mask_d  = s1_mask_q;
        if (bus.in_valid) begin
            s1_vec_d  = rounded;
            s1_addr_d = bus.in_addr;
            s1_be_d   = bus.in_be;
            s1_mask_d = bus.in_mask;
        end
    end

    // ------------------------------------------------------------------
    // Writeback FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_vec_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_vec_d  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_d [FIFO_DEPTH];
    logic [BE_WIDTH-1:0]   mem_be_q   [FIFO_DEPTH];
    logic [BE_WIDTH-1:0]   mem_be_d   [FIFO_DEPTH];
    logic                  mem_mask_q [FIFO_DEPTH];
    logic                  mem_mask_d [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic not_empty;
    logic is_full;
    logic pop;
    logic wr_en;

    assign not_empty = (count_q != '0);
    assign is_full   = (count_q == DEPTH_C);
    assign pop       = not_empty & bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    // With count==FIFO_DEPTH the write slot equals the head slot; the head is
    // read combinationally this cycle and overwritten at the edge.
    assign wr_en     = s1_valid_q & (~is_full | pop);

    always_comb begin
        mem_vec_d  = mem_vec_q;
        mem_addr_d = mem_addr_q;
        mem_be_d   = mem_be_q;
        mem_mask_d = mem_mask_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            mem_vec_d[wr_ptr_q]  = s1_vec_q;
            mem_addr_d[wr_ptr_q] = s1_addr_q;
            mem_be_d[wr_ptr_q]   = s1_be_q;
            mem_mask_d[wr_ptr_q] = s1_mask_q;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        if (s1_valid_q && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_vec_q   <= '0;
            s1_addr_q  <= '0;
            s1_be_q    <= '0;
            s1_mask_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_vec_q[i]  <= '0;
                mem_addr_q[i] <= '0;
                mem_be_q[i]   <= '0;
                mem_mask_q[i] <= 1'b0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_vec_q   <= s1_vec_d;
            s1_addr_q  <= s1_addr_d;
            s1_be_q    <= s1_be_d;
            s1_mask_q  <= s1_mask_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_vec_q[i]  <= mem_vec_d[i];
                mem_addr_q[i] <= mem_addr_d[i];
                mem_be_q[i]   <= mem_be_d[i];
                mem_mask_q[i] <= mem_mask_d[i];
            end
        end
    end

    // Head fields are forced to zero while empty so that reset (which clears
    // count asynchronously) zeroes the outputs without clearing storage first.
    assign bus.out_valid = not_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.out_vec   = not_empty ? mem_vec_q[rd_ptr_q]  : '0;
    assign bus.out_addr  = not_empty ? mem_addr_q[rd_ptr_q] : '0;
    assign bus.out_be    = not_empty ? mem_be_q[rd_ptr_q]   : '0;
    assign bus.out_mask  = not_empty ? mem_mask_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_vfxp_round_wb.sv
// tb/tb_vfxp_round_wb.sv - self-checking bench for vfxp_round_wb

module tb_vfxp_round_wb;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    vfxp_round_wb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BE_WIDTH(8)) bus ();

    vfxp_round_wb #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(32),
        .BE_WIDTH  (8),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rounding: split the word into 2^sew-byte elements, add the
    // rounding bit to each one as an integer and wrap it at its width.
    function automatic logic [63:0] ref_round(input logic [63:0] v, input logic [7:0] vd,
                                              input logic [7:0] vd1, input logic [1:0] sew,
                                              input logic [1:0] vxrm, input logic fxp,
                                              input logic mask);
        int nbytes;
        int w;
        logic [63:0] wmask;
        logic [63:0] elem;
        logic [63:0] res;
        logic r;
        if (!fxp || mask) return v;
        nbytes = 1 << sew;
        w      = 8 * nbytes;
        wmask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        res    = 64'd0;
        for (int e = 0; e < 8 / nbytes; e++) begin
            case (vxrm)
                2'd0:    r = vd1[e*nbytes];
                2'd1:    r = vd1[e*nbytes] && vd[e*nbytes];
                2'd2:    r = 1'b0;
                default: r = vd1[e*nbytes] && !vd[e*nbytes];
            endcase
            elem = (v >> (e * w)) & wmask;
            elem = (elem + {63'd0, r}) & wmask;
            res  = res | (elem << (e * w));
        end
        return res;
    endfunction

    typedef struct {
        logic [63:0] vec;
        logic [31:0] addr;
        logic [7:0]  be;
        logic        mask;
    } ent_t;

    ent_t m_q[$];
    logic m_s1_v = 1'b0;
    ent_t m_s1;
    logic m_ovf  = 1'b0;

    // Model: one register stage, then a bounded queue.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_s1_v = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            int  old_size;
            logic do_pop;
            old_size = m_q.size();
            do_pop   = (old_size > 0) && (bus.out_ready === 1'b1);
            if (do_pop) void'(m_q.pop_front());
            if (m_s1_v) begin
                if (old_size < DEPTH || do_pop) m_q.push_back(m_s1);
                else m_ovf = 1'b1;
            end
            m_s1_v      = bus.in_valid;
            m_s1.vec    = ref_round(bus.in_vec, bus.in_vd, bus.in_vd1, bus.in_sew,
                                    bus.in_vxrm, bus.in_fxp, bus.in_mask);
            m_s1.addr   = bus.in_addr;
            m_s1.be     = bus.in_be;
            m_s1.mask   = bus.in_mask;
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        logic ev;
        ev = (m_q.size() != 0);
        check("cmp out_valid", {63'd0, bus.out_valid}, {63'd0, ev});
        check("cmp full", {63'd0, bus.full}, {63'd0, m_q.size() == DEPTH});
        check("cmp overflow", {63'd0, bus.overflow}, {63'd0, m_ovf});
        if (ev) begin
            check("cmp out_vec", bus.out_vec, m_q[0].vec);
            check("cmp out_addr", {32'd0, bus.out_addr}, {32'd0, m_q[0].addr});
            check("cmp out_be", {56'd0, bus.out_be}, {56'd0, m_q[0].be});
            check("cmp out_mask", {63'd0, bus.out_mask}, {63'd0, m_q[0].mask});
        end else begin
            check("cmp idle out_vec", bus.out_vec, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [63:0] vec, input logic [7:0] vd, input logic [7:0] vd1,
                          input logic [1:0] sew, input logic [1:0] vxrm, input logic fxp,
                          input logic mask);
        bus.in_valid = 1'b1;
        bus.in_vec   = vec;
        bus.in_vd    = vd;
        bus.in_vd1   = vd1;
        bus.in_sew   = sew;
        bus.in_vxrm  = vxrm;
        bus.in_fxp   = fxp;
        bus.in_mask  = mask;
        bus.in_addr  = $urandom;
        bus.in_be    = 8'($urandom);
    endtask

    // Single word into an empty FIFO: absent after one edge, present after two,
    // gone after one pop.
    task automatic send_one(input string name, input logic [63:0] vec, input logic [7:0] vd,
                            input logic [7:0] vd1, input logic [1:0] sew, input logic [1:0] vxrm,
                            input logic fxp, input logic mask, input logic [63:0] expv);
        check({name, " model"}, ref_round(vec, vd, vd1, sew, vxrm, fxp, mask), expv);
        bus.out_ready = 1'b0;
        set_in(vec, vd, vd1, sew, vxrm, fxp, mask);
        tick();
        bus.in_valid = 1'b0;
        check({name, " valid after 1"}, {63'd0, bus.out_valid}, 64'd0);
        tick();
        check({name, " valid after 2"}, {63'd0, bus.out_valid}, 64'd1);
        check({name, " out_vec"}, bus.out_vec, expv);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, " drained"}, {63'd0, bus.out_valid}, 64'd0);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic reset_mid(input string name);
        #2;
        rst = 1'b1;
        #1;
        check({name, " rst out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({name, " rst full"}, {63'd0, bus.full}, 64'd0);
        check({name, " rst overflow"}, {63'd0, bus.overflow}, 64'd0);
        check({name, " rst out_vec"}, bus.out_vec, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.in_addr   = '0;
        bus.in_be     = '0;
        bus.in_mask   = 1'b0;
        bus.in_fxp    = 1'b0;
        bus.in_vd     = '0;
        bus.in_vd1    = '0;
        bus.in_sew    = '0;
        bus.in_vxrm   = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        #12;
        check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset full", {63'd0, bus.full}, 64'd0);
        check("reset overflow", {63'd0, bus.overflow}, 64'd0);
        check("reset out_vec", bus.out_vec, 64'd0);
        check("reset out_addr", {32'd0, bus.out_addr}, 64'd0);
        check("reset out_be", {56'd0, bus.out_be}, 64'd0);
        check("reset out_mask", {63'd0, bus.out_mask}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        send_one("rnu byte", 64'h03, 8'h00, 8'h01, 2'd0, 2'd0, 1'b1, 1'b0, 64'h04);
        send_one("rne bytes", 64'h0302, 8'h02, 8'h03, 2'd0, 2'd1, 1'b1, 1'b0, 64'h0402);
        send_one("rnu half wrap", 64'h0000_0000_1234_FFFF, 8'h00, 8'h01, 2'd1, 2'd0, 1'b1, 1'b0,
                 64'h0000_0000_1234_0000);
        send_one("rod word", 64'h0000_0005_0000_0007, 8'h10, 8'h11, 2'd2, 2'd3, 1'b1, 1'b0,
                 64'h0000_0005_0000_0008);
        send_one("rdn dword", 64'h0123_4567_89AB_CDEF, 8'h00, 8'hFF, 2'd3, 2'd2, 1'b1, 1'b0,
                 64'h0123_4567_89AB_CDEF);
        send_one("rnu dword wrap", 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h01, 2'd3, 2'd0, 1'b1, 1'b0,
                 64'h0);
        send_one("mask pass", 64'h00FF_00FF_00FF_00FF, 8'h00, 8'hFF, 2'd0, 2'd0, 1'b1, 1'b1,
                 64'h00FF_00FF_00FF_00FF);
        send_one("no fxp pass", 64'h00FF_00FF_00FF_00FF, 8'h00, 8'hFF, 2'd0, 2'd0, 1'b0, 1'b0,
                 64'h00FF_00FF_00FF_00FF);

        // Five back-to-back words against a stalled consumer.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_in(64'(i), 8'h00, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("ovf full after 4", {63'd0, bus.full}, 64'd1);
        check("ovf not yet", {63'd0, bus.overflow}, 64'd0);
        tick();
        check("ovf set", {63'd0, bus.overflow}, 64'd1);
        check("ovf still full", {63'd0, bus.full}, 64'd1);
        tick();
        check("ovf head stable", bus.out_vec, 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf pop order", bus.out_vec, 64'(i));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        check("ovf drained", {63'd0, bus.out_valid}, 64'd0);
        check("ovf sticky", {63'd0, bus.overflow}, 64'd1);
        reset_mid("clr ovf");

        // Push and pop together while full.
        for (int i = 1; i <= 5; i++) begin
            set_in(64'(10 + i), 8'h00, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("pp full before", {63'd0, bus.full}, 64'd1);
        bus.out_ready = 1'b1;
        tick();
        check("pp full kept", {63'd0, bus.full}, 64'd1);
        check("pp no overflow", {63'd0, bus.overflow}, 64'd0);
        for (int i = 2; i <= 5; i++) begin
            check("pp order", bus.out_vec, 64'(10 + i));
            tick();
        end
        check("pp drained", {63'd0, bus.out_valid}, 64'd0);
        bus.out_ready = 1'b0;

        // Reset with two entries buffered.
        set_in(64'hAA, 8'h00, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
        tick();
        set_in(64'hBB, 8'h00, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid rst has data", {63'd0, bus.out_valid}, 64'd1);
        reset_mid("mid rst");
        send_one("post rst", 64'h03, 8'h00, 8'h01, 2'd0, 2'd0, 1'b1, 1'b0, 64'h04);

        // Randomized traffic with varying consumer stalls and rare resets.
        begin
            int bias;
            bias = 5;
            for (int c = 0; c < 4000; c++) begin
                if (c % 250 == 0) bias = $urandom_range(1, 9);
                if ($urandom_range(0, 299) == 0) begin
                    reset_mid("rand");
                end
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.in_vec    = {$urandom, $urandom};
                bus.in_addr   = $urandom;
                bus.in_be     = 8'($urandom);
                bus.in_vd     = 8'($urandom);
                bus.in_vd1    = 8'($urandom);
                bus.in_sew    = 2'($urandom);
                bus.in_vxrm   = 2'($urandom);
                bus.in_fxp    = ($urandom_range(0, 3) != 0);
                bus.in_mask   = ($urandom_range(0, 7) == 0);
                bus.out_ready = ($urandom_range(0, 9) < bias);
                tick();
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) tick();
        check("final drained", {63'd0, bus.out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
